rev_apb_master: RTL and testbench

//  APB initiator bridging a simple valid/ready request/response port to the APB peripheral bus
//  (gpio, uart, timers). Converts one request into a SETUP/ACCESS transfer, waits on pready and

---
 rtl/rev_apb_master_pkg.sv | 32 +++
 rtl/rev_apb_master_if.sv | 46 ++++
 rtl/rev_apb_master.sv | 134 +++++++++++++
 tb/tb_rev_apb_master.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rev_apb_master_pkg.sv
// rev_apb_pkg: shared types for the APB initiator and the peripheral wrappers
// (gpio, uart, timers) that sit behind it.
//   apb_state_e : initiator FSM states
//   apb_req_t   : request bundle at the default widths
//   apb_rsp_t   : response bundle at the default widths
package rev_apb_pkg;

  localparam int APB_ADDR_W  = 4;
  localparam int APB_DATA_W  = 32;
  localparam int APB_STRB_W  = APB_DATA_W / 8;
  localparam int APB_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/rev_apb_master_if.sv
// rev_apb_master_if: request/response handshake plus APB bus of the initiator.
//   master modport : the bridge (drives req_ready_o, rsp_*, APB controls)
//   slave  modport : the requester/peripheral side (mirror of master)
interface rev_apb_master_if #(
  parameter int ADDR_W = rev_apb_pkg::APB_ADDR_W,
  parameter int DATA_W = rev_apb_pkg::APB_DATA_W
);
  localparam int STRB_W = DATA_W / 8;

  // request / response port
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic              req_write_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic [STRB_W-1:0] req_strb_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  // APB bus
  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwrdata;
  logic [STRB_W-1:0] pstrb;
  logic              pready;
  logic [DATA_W-1:0] prddata;
  logic              pslverr;

  modport master (
    input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i,
           rsp_ready_i, pready, prddata, pslverr,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           psel, penable, paddr, pwrite, pwrdata, pstrb
  );

  modport slave (
    output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i,
           rsp_ready_i, pready, prddata, pslverr,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           psel, penable, paddr, pwrite, pwrdata, pstrb
  );

endinterface

// File: rtl/rev_apb_master.sv
// rev_apb_master: APB initiator. Takes one valid/ready request, runs a
// SETUP/ACCESS transfer, returns read data and error status, and aborts an
// ACCESS that waits too long on pready. One transfer in flight at a time.
//   pclk  : clock
//   prstn : synchronous active-low reset
//   bus   : rev_apb_master_if.master (req/rsp handshake + APB bus)
module rev_apb_master
  import rev_apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic          pclk,
  input  logic          prstn,
  rev_apb_master_if.master bus
);

  localparam int STRB_W = DATA_W / 8;
  // Counter only needs to reach TIMEOUT-1; keep at least one bit for TIMEOUT=0.
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  apb_state_e        r_state, w_state;
  logic              r_psel, w_psel;
  logic              r_penable, w_penable;
  logic [ADDR_W-1:0] r_paddr, w_paddr;
  logic              r_pwrite, w_pwrite;
  logic [DATA_W-1:0] r_pwrdata, w_pwrdata;
  logic [STRB_W-1:0] r_pstrb, w_pstrb;
  logic              r_rsp_valid, w_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;
  logic              r_rsp_err, w_rsp_err;
  logic [CNT_W-1:0]  r_cnt, w_cnt;

  always_comb begin
    w_state     = r_state;
    w_psel      = r_psel;
    w_penable   = r_penable;
    w_paddr     = r_paddr;
    w_pwrite    = r_pwrite;
    w_pwrdata   = r_pwrdata;
    w_pstrb     = r_pstrb;
    w_rsp_valid = r_rsp_valid;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_err   = r_rsp_err;
    w_cnt       = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.req_valid_i) begin
          w_paddr   = bus.req_addr_i;
          w_pwrite  = bus.req_write_i;
          w_pwrdata = bus.req_wdata_i;
          // reads never drive strobes
          w_pstrb   = bus.req_write_i ? bus.req_strb_i : '0;
          w_psel    = 1'b1;
          w_cnt     = '0;
          w_state   = SETUP;
        end
      end
      SETUP: begin
        w_penable = 1'b1;
        w_state   = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          // pready wins over an expiry landing on the same cycle
          w_rsp_rdata = (r_pwrite || bus.pslverr) ? '0 : bus.prddata;
          w_rsp_err   = bus.pslverr;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_state     = RESP;
        end else if (TIMEOUT != 0 && r_cnt == CNT_LAST) begin
          w_rsp_rdata = '0;
          w_rsp_err   = 1'b1;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_state     = RESP;
        end else if (r_cnt != '1) begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          w_rsp_valid = 1'b0;
          w_state     = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!prstn) begin
      r_state     <= IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwrdata   <= '0;
      r_pstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_paddr     <= w_paddr;
      r_pwrite    <= w_pwrite;
      r_pwrdata   <= w_pwrdata;
      r_pstrb     <= w_pstrb;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= w_rsp_err;
      r_cnt       <= w_cnt;
    end
  end

  assign bus.req_ready_o = (r_state == IDLE);
  assign bus.psel        = r_psel;
  assign bus.penable     = r_penable;
  assign bus.paddr       = r_paddr;
  assign bus.pwrite      = r_pwrite;
  assign bus.pwrdata     = r_pwrdata;
  assign bus.pstrb       = r_pstrb;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_rev_apb_master.sv
// tb_rev_apb_master: directed bench for rev_apb_master. Instance A uses the
// default timeout, instance B uses TIMEOUT=4 for the abort cases. Expected
// responses are queued at issue time and popped when rsp_valid_o appears.
module tb_rev_apb_master;
  import rev_apb_pkg::*;

  logic pclk;
  logic prstn;

  rev_apb_master_if #(.ADDR_W(4), .DATA_W(32)) ifa ();
  rev_apb_master_if #(.ADDR_W(4), .DATA_W(32)) ifb ();

  rev_apb_master #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(255)) dut_a (
    .pclk (pclk),
    .prstn(prstn),
    .bus  (ifa)
  );

  rev_apb_master #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(4)) dut_b (
    .pclk (pclk),
    .prstn(prstn),
    .bus  (ifb)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int vectors = 0;
  int miscompares = 0;
  apb_rsp_t qa[$];
  apb_rsp_t qb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // outputs are sampled 1ns after the active edge; inputs change there too
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic issue_a(input logic [3:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s);
    ifa.req_valid_i = 1'b1;
    ifa.req_addr_i  = a;
    ifa.req_write_i = w;
    ifa.req_wdata_i = d;
    ifa.req_strb_i  = s;
  endtask

  task automatic issue_b();
    ifb.req_valid_i = 1'b1;
    ifb.req_addr_i  = 4'h9;
    ifb.req_write_i = 1'b0;
    ifb.req_wdata_i = 32'h0;
    ifb.req_strb_i  = 4'h0;
  endtask

  // compare the current A response against the scoreboard head
  task automatic pop_a(input string tag);
    apb_rsp_t e;
    chk({tag, "_vld"}, 32'(ifa.rsp_valid_o), 32'd1);
    chk({tag, "_qsz"}, 32'(qa.size() > 0), 32'd1);
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk({tag, "_rdata"}, ifa.rsp_rdata_o, e.rdata);
      chk({tag, "_err"}, 32'(ifa.rsp_err_o), 32'(e.err));
    end
  endtask

  task automatic pop_b(input string tag);
    apb_rsp_t e;
    chk({tag, "_vld"}, 32'(ifb.rsp_valid_o), 32'd1);
    chk({tag, "_qsz"}, 32'(qb.size() > 0), 32'd1);
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk({tag, "_rdata"}, ifb.rsp_rdata_o, e.rdata);
      chk({tag, "_err"}, 32'(ifb.rsp_err_o), 32'(e.err));
    end
  endtask

  initial begin
    prstn = 1'b0;
    ifa.req_valid_i = 1'b0; ifa.req_addr_i = '0; ifa.req_write_i = 1'b0;
    ifa.req_wdata_i = '0;   ifa.req_strb_i = '0; ifa.rsp_ready_i = 1'b1;
    ifa.pready = 1'b0;      ifa.prddata = '0;    ifa.pslverr = 1'b0;
    ifb.req_valid_i = 1'b0; ifb.req_addr_i = '0; ifb.req_write_i = 1'b0;
    ifb.req_wdata_i = '0;   ifb.req_strb_i = '0; ifb.rsp_ready_i = 1'b1;
    ifb.pready = 1'b0;      ifb.prddata = '0;    ifb.pslverr = 1'b0;
    tick();
    tick();

    // ---- reset state
    chk("rst_req_ready", 32'(ifa.req_ready_o), 32'd1);
    chk("rst_psel",      32'(ifa.psel), 32'd0);
    chk("rst_penable",   32'(ifa.penable), 32'd0);
    chk("rst_rsp_valid", 32'(ifa.rsp_valid_o), 32'd0);
    chk("rst_paddr",     32'(ifa.paddr), 32'd0);
    chk("rst_pwrite",    32'(ifa.pwrite), 32'd0);
    chk("rst_pwrdata",   ifa.pwrdata, 32'd0);
    chk("rst_pstrb",     32'(ifa.pstrb), 32'd0);
    chk("rst_rsp_err",   32'(ifa.rsp_err_o), 32'd0);
    prstn = 1'b1;
    tick();

    // ---- write, zero-wait: psel@1, penable@2, rsp@3
    ifa.pready = 1'b1;
    issue_a(4'h1, 1'b1, 32'hA5A5_5A5A, 4'hF);
    chk("wr_c0_ready", 32'(ifa.req_ready_o), 32'd1);
    qa.push_back('{rdata: 32'h0, err: 1'b0});
    tick();
    ifa.req_valid_i = 1'b0;
    chk("wr_c1_psel",    32'(ifa.psel), 32'd1);
    chk("wr_c1_penable", 32'(ifa.penable), 32'd0);
    chk("wr_c1_paddr",   32'(ifa.paddr), 32'h1);
    chk("wr_c1_pwrite",  32'(ifa.pwrite), 32'd1);
    chk("wr_c1_pwrdata", ifa.pwrdata, 32'hA5A5_5A5A);
    chk("wr_c1_pstrb",   32'(ifa.pstrb), 32'hF);
    chk("wr_c1_ready",   32'(ifa.req_ready_o), 32'd0);
    tick();
    chk("wr_c2_psel",    32'(ifa.psel), 32'd1);
    chk("wr_c2_penable", 32'(ifa.penable), 32'd1);
    chk("wr_c2_pwrdata", ifa.pwrdata, 32'hA5A5_5A5A);
    chk("wr_c2_rspv",    32'(ifa.rsp_valid_o), 32'd0);
    tick();
    pop_a("wr_c3");
    chk("wr_c3_psel",    32'(ifa.psel), 32'd0);
    chk("wr_c3_penable", 32'(ifa.penable), 32'd0);
    tick();
    chk("wr_c4_ready",   32'(ifa.req_ready_o), 32'd1);
    chk("wr_c4_rspv",    32'(ifa.rsp_valid_o), 32'd0);

    // ---- read with 5 wait states; pslverr without pready is ignored
    ifa.pready = 1'b0;
    ifa.pslverr = 1'b1;
    ifa.prddata = 32'hDEAD_BEEF;
    issue_a(4'h3, 1'b0, 32'hFFFF_FFFF, 4'hF);
    qa.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    tick();
    ifa.req_valid_i = 1'b0;
    chk("rd_setup_pstrb",  32'(ifa.pstrb), 32'd0);
    chk("rd_setup_pwrite", 32'(ifa.pwrite), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rd_wait%0d_pen", i),   32'(ifa.penable), 32'd1);
      chk($sformatf("rd_wait%0d_paddr", i), 32'(ifa.paddr), 32'h3);
      chk($sformatf("rd_wait%0d_pstrb", i), 32'(ifa.pstrb), 32'd0);
      chk($sformatf("rd_wait%0d_rspv", i),  32'(ifa.rsp_valid_o), 32'd0);
      tick();
    end
    ifa.pready = 1'b1;
    ifa.pslverr = 1'b0;
    ifa.prddata = 32'h1234_5678;
    chk("rd_last_pen", 32'(ifa.penable), 32'd1);
    tick();
    pop_a("rd");
    tick();

    // ---- read with pslverr on completion
    ifa.pslverr = 1'b1;
    ifa.prddata = 32'h0;
    issue_a(4'h2, 1'b0, 32'h0, 4'h0);
    qa.push_back('{rdata: 32'h0, err: 1'b1});
    tick();
    ifa.req_valid_i = 1'b0;
    tick();
    tick();
    pop_a("rderr");
    ifa.pslverr = 1'b0;
    tick();

    // ---- response back-pressure: outputs hold, new request not taken
    ifa.rsp_ready_i = 1'b0;
    ifa.pslverr = 1'b1;
    issue_a(4'h5, 1'b1, 32'h0F0F_0F0F, 4'h0);
    qa.push_back('{rdata: 32'h0, err: 1'b1});
    tick();
    chk("bp_pstrb_zero", 32'(ifa.pstrb), 32'd0);
    issue_a(4'hE, 1'b0, 32'h0, 4'h0);
    tick();
    tick();
    pop_a("bp");
    ifa.pslverr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp%0d_rspv", i),  32'(ifa.rsp_valid_o), 32'd1);
      chk($sformatf("bp%0d_err", i),   32'(ifa.rsp_err_o), 32'd1);
      chk($sformatf("bp%0d_rdata", i), ifa.rsp_rdata_o, 32'd0);
      chk($sformatf("bp%0d_ready", i), 32'(ifa.req_ready_o), 32'd0);
      chk($sformatf("bp%0d_psel", i),  32'(ifa.psel), 32'd0);
      tick();
    end
    ifa.req_valid_i = 1'b0;
    ifa.rsp_ready_i = 1'b1;
    tick();
    chk("bp_done_rspv",  32'(ifa.rsp_valid_o), 32'd0);
    chk("bp_done_ready", 32'(ifa.req_ready_o), 32'd1);
    chk("bp_done_psel",  32'(ifa.psel), 32'd0);

    // ---- reset in ACCESS drops the transfer
    ifa.pready = 1'b0;
    issue_a(4'h7, 1'b0, 32'h0, 4'h0);
    tick();
    ifa.req_valid_i = 1'b0;
    tick();
    chk("rstx_in_access", 32'(ifa.penable), 32'd1);
    prstn = 1'b0;
    tick();
    chk("rstx_psel",  32'(ifa.psel), 32'd0);
    chk("rstx_pen",   32'(ifa.penable), 32'd0);
    chk("rstx_ready", 32'(ifa.req_ready_o), 32'd1);
    chk("rstx_rspv",  32'(ifa.rsp_valid_o), 32'd0);
    prstn = 1'b1;
    ifa.pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rstx_quiet%0d", i), 32'(ifa.rsp_valid_o | ifa.psel), 32'd0);
    end
    chk("qa_empty", 32'(qa.size()), 32'd0);

    // ---- TIMEOUT=4: stuck pready aborts after 4th ACCESS cycle
    ifb.prddata = 32'hDEAD_BEEF;
    issue_b();
    qb.push_back('{rdata: 32'h0, err: 1'b1});
    tick();
    ifb.req_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to%0d_pen", i),  32'(ifb.penable), 32'd1);
      chk($sformatf("to%0d_rspv", i), 32'(ifb.rsp_valid_o), 32'd0);
      tick();
    end
    pop_b("to_abort");
    chk("to_abort_psel", 32'(ifb.psel), 32'd0);
    tick();

    // pready on the expiry cycle completes normally
    issue_b();
    qb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
    tick();
    ifb.req_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) tick();
    ifb.pready = 1'b1;
    ifb.prddata = 32'hCAFE_F00D;
    chk("toe_last_pen", 32'(ifb.penable), 32'd1);
    tick();
    pop_b("to_edge");
    tick();
    chk("toe_idle", 32'(ifb.req_ready_o), 32'd1);
    chk("qb_empty", 32'(qb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
